// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash responder and the flash read controller.
//   - opcode constants for the supported serial NOR commands
//   - responder state encoding (3 bits)
package spi_flash_pkg;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_RDSR      = 8'h05;
    localparam logic [7:0] CMD_RDID      = 8'h9F;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_RDSR   = 3'd4;
    localparam logic [2:0] S_RDID   = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;
    localparam logic [2:0] S_DUMMY  = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE   = S_IDLE,
        ST_CMD    = S_CMD,
        ST_ADDR   = S_ADDR,
        ST_DATA   = S_DATA,
        ST_RDSR   = S_RDSR,
        ST_RDID   = S_RDID,
        ST_IGNORE = S_IGNORE,
        ST_DUMMY  = S_DUMMY
    } state_t;

endpackage

// File: rtl/spi_flash_responder_if.sv
// Byte-wide synchronous memory read port of the SPI flash responder.
//   o_MEM_ADDR : read address (responder -> memory)
//   o_MEM_RD   : one-clk read strobe (responder -> memory)
//   i_MEM_DATA : read data, valid one clk after o_MEM_RD (memory -> responder)
// master = responder side, slave = memory side.
interface spi_flash_responder_if #(
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0] o_MEM_ADDR;
    logic              o_MEM_RD;
    logic [7:0]        i_MEM_DATA;

    modport master (
        output o_MEM_ADDR,
        output o_MEM_RD,
        input  i_MEM_DATA
    );

    modport slave (
        input  o_MEM_ADDR,
        input  o_MEM_RD,
        output i_MEM_DATA
    );
endinterface

// File: rtl/spi_edge_sync.sv
// Synchronizer for the asynchronous SPI inputs plus edge pulses.
//   clk, reset     : system clock, synchronous active-low reset
//   sck_in/mosi_in/cs_in : raw SPI pins
//   mosi_s, cs_s   : synchronized MOSI and CS (CS active low)
//   sck_rise/fall  : one-clk pulses on synchronized SCK edges
//   cs_rise/fall   : one-clk pulses on synchronized CS edges
// SCK and MOSI pass through equal-depth chains so MOSI stays aligned with
// the SCK edge it belongs to. CS resets to the deasserted level so that
// leaving reset never fabricates a CS falling edge.
module spi_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sck_in,
    input  logic mosi_in,
    input  logic cs_in,
    output logic mosi_s,
    output logic cs_s,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_rise,
    output logic cs_fall
);

    logic [SYNC_STAGES-1:0] sck_q, sck_d;
    logic [SYNC_STAGES-1:0] mosi_q, mosi_d;
    logic [SYNC_STAGES-1:0] cs_q, cs_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   cs_prev_q, cs_prev_d;

    always_comb begin
        sck_d      = {sck_q[SYNC_STAGES-2:0], sck_in};
        mosi_d     = {mosi_q[SYNC_STAGES-2:0], mosi_in};
        cs_d       = {cs_q[SYNC_STAGES-2:0], cs_in};
        sck_prev_d = sck_q[SYNC_STAGES-1];
        cs_prev_d  = cs_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_q      <= '0;
            mosi_q     <= '0;
            cs_q       <= '1;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
        end else begin
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_q       <= cs_d;
            sck_prev_q <= sck_prev_d;
            cs_prev_q  <= cs_prev_d;
        end
    end

    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign cs_s     = cs_q[SYNC_STAGES-1];
    assign sck_rise =  sck_q[SYNC_STAGES-1] & ~sck_prev_q;
    assign sck_fall = ~sck_q[SYNC_STAGES-1] &  sck_prev_q;
    assign cs_rise  =  cs_q[SYNC_STAGES-1]  & ~cs_prev_q;
    assign cs_fall  = ~cs_q[SYNC_STAGES-1]  &  cs_prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI Mode 0 target emulating a serial NOR flash (READ, RDSR, RDID).
// All SPI pins are oversampled on clk; nothing is clocked by SCK.
//   clk, reset        : system clock, synchronous active-low reset
//   i_SPI_CLK/MOSI/CS : SPI initiator pins (CS active low)
//   o_SPI_MISO(_OE)   : target data and drive enable (tristate built above)
//   o_BUSY            : synchronized CS asserted
//   mem               : byte-wide synchronous memory read port (master)
// Optional feature macro: SPI_FAST_READ_EN enables FAST_READ (0x0B) with
// an 8-cycle dummy phase; undefined, 0x0B is ignored like any unknown opcode.
//
// state  | meaning
// IDLE   | CS deasserted, waiting for CS falling edge
// CMD    | shifting in the opcode byte
// ADDR   | shifting in the 24-bit address
// DUMMY  | FAST_READ dummy byte, MISO not driven, first byte prefetched
// DATA   | streaming memory bytes, address auto-increments and wraps
// RDSR   | returning status 0x00 forever
// RDID   | returning JEDEC ID bytes, then 0x00
// IGNORE | unknown opcode, silent until CS deasserts
module spi_flash_responder
    import spi_flash_pkg::*;
#(
    parameter int          ADDR_W      = 12,
    parameter logic [23:0] JEDEC_ID    = 24'hEF4016,
    parameter int          SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_SPI_CLK,
    input  logic                 i_SPI_MOSI,
    input  logic                 i_SPI_CS,
    output logic                 o_SPI_MISO,
    output logic                 o_SPI_MISO_OE,
    output logic                 o_BUSY,
    spi_flash_responder_if.master mem
);

    logic mosi_s, cs_s, sck_rise, sck_fall, cs_rise, cs_fall;

    spi_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .reset    (reset),
        .sck_in   (i_SPI_CLK),
        .mosi_in  (i_SPI_MOSI),
        .cs_in    (i_SPI_CS),
        .mosi_s   (mosi_s),
        .cs_s     (cs_s),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_rise  (cs_rise),
        .cs_fall  (cs_fall)
    );

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    // Only seven bits are held: the eighth bit of a byte is used live.
    logic [6:0]        rx_q, rx_d;
    logic [ADDR_W-2:0] addr_q, addr_d;
    logic [7:0]        tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              rd_dly_q, rd_dly_d;
    logic              fast_q, fast_d;

    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_next;
    logic              byte_done;

    assign rx_byte   = {rx_q, mosi_s};
    assign addr_next = {addr_q, mosi_s};
    assign byte_done = sck_rise && (bit_cnt_q == 3'd7);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        rx_d       = rx_q;
        addr_d     = addr_q;
        tx_d       = tx_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = 1'b0;
        rd_dly_d   = mem_rd_q;
        fast_d     = fast_q;

        // CS deassertion wins over any SCK edge seen in the same clk.
        if (cs_s || cs_rise) begin
            state_d   = ST_IDLE;
            oe_d      = 1'b0;
            miso_d    = 1'b0;
            bit_cnt_d = 3'd0;
        end else begin
            if (sck_rise && (state_q != ST_IDLE)) begin
                rx_d      = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d    = ST_CMD;
                        bit_cnt_d  = 3'd0;
                        byte_cnt_d = 2'd0;
                        rx_d       = '0;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        byte_cnt_d = 2'd0;
                        fast_d     = 1'b0;
                        case (rx_byte)
                            CMD_READ: state_d = ST_ADDR;
                            CMD_RDSR: state_d = ST_RDSR;
                            CMD_RDID: begin
                                state_d    = ST_RDID;
                                tx_d       = JEDEC_ID[23:16];
                                byte_cnt_d = 2'd1;
                            end
`ifdef SPI_FAST_READ_EN
                            CMD_FAST_READ: begin
                                state_d = ST_ADDR;
                                fast_d  = 1'b1;
                            end
`endif
                            default: state_d = ST_IGNORE;
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        addr_d = addr_next[ADDR_W-2:0];
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd2) begin
                                mem_addr_d = addr_next;
                                mem_rd_d   = 1'b1;
                                state_d    = fast_q ? ST_DUMMY : ST_DATA;
                            end
                        end
                    end
                end
                ST_DUMMY: begin
                    if (byte_done) state_d = ST_DATA;
                end
                ST_DATA: begin
                    if (sck_fall) begin
                        oe_d   = 1'b1;
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    // Prefetch the next byte; it lands well before the next falling edge.
                    if (byte_done) begin
                        mem_addr_d = mem_addr_q + ADDR_W'(1);
                        mem_rd_d   = 1'b1;
                    end
                end
                ST_RDSR: begin
                    if (sck_fall) begin
                        oe_d   = 1'b1;
                        miso_d = 1'b0;
                    end
                end
                ST_RDID: begin
                    if (sck_fall) begin
                        oe_d   = 1'b1;
                        miso_d = tx_q[7];
                        tx_d   = {tx_q[6:0], 1'b0};
                    end
                    if (byte_done) begin
                        case (byte_cnt_q)
                            2'd1:    tx_d = JEDEC_ID[15:8];
                            2'd2:    tx_d = JEDEC_ID[7:0];
                            default: tx_d = 8'h00;
                        endcase
                        if (byte_cnt_q != 2'd3) byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
                ST_IGNORE: begin
                end
                default: state_d = ST_IDLE;
            endcase

            if (rd_dly_q) tx_d = mem.i_MEM_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 2'd0;
            rx_q       <= '0;
            addr_q     <= '0;
            tx_q       <= 8'h00;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            rd_dly_q   <= 1'b0;
            fast_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            rx_q       <= rx_d;
            addr_q     <= addr_d;
            tx_q       <= tx_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            rd_dly_q   <= rd_dly_d;
            fast_q     <= fast_d;
        end
    end

    assign o_SPI_MISO     = miso_q & oe_q;
    assign o_SPI_MISO_OE  = oe_q;
    assign o_BUSY         = ~cs_s;
    assign mem.o_MEM_ADDR = mem_addr_q;
    assign mem.o_MEM_RD   = mem_rd_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed testbench for spi_flash_responder: acts as a Mode 0 SPI initiator
// and a synchronous memory, checks received bytes against a memory-array
// model and literal values, and checks per-cycle output rules.
module tb_spi_flash_responder;

    localparam int ADDR_W      = 12;
    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1;
    logic miso, miso_oe, busy;

    spi_flash_responder_if #(.ADDR_W(ADDR_W)) mem_if ();

    spi_flash_responder #(
        .ADDR_W(ADDR_W), .JEDEC_ID(24'hEF4016), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .reset(reset),
        .i_SPI_CLK(spi_sck), .i_SPI_MOSI(spi_mosi), .i_SPI_CS(spi_cs),
        .o_SPI_MISO(miso), .o_SPI_MISO_OE(miso_oe), .o_BUSY(busy),
        .mem(mem_if)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:4095];
    always @(posedge clk) begin
        if (mem_if.o_MEM_RD) mem_if.i_MEM_DATA <= mem[mem_if.o_MEM_ADDR];
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Per-cycle rules: MISO gated by OE, single-clk read strobes, reads only
    // inside READ transactions, o_BUSY = CS asserted after the sync latency.
    logic mon_en = 1'b0, busy_en = 1'b0, rd_ok = 1'b0, prev_rd = 1'b0;
    logic [7:0] cs_hist = 8'hFF;
    logic [ADDR_W-1:0] rd_log [$];
    logic [7:0] rx_seen [$];

    always @(posedge clk) begin
        logic v_gate, v_single, v_allow, v_exp_busy, v_busy;
        #1;
        if (mon_en) begin
            v_gate     = miso & ~miso_oe;
            v_single   = mem_if.o_MEM_RD & prev_rd;
            v_allow    = mem_if.o_MEM_RD & ~rd_ok;
            check("miso_gate", {31'b0, v_gate}, 32'd0);
            check("rd_single", {31'b0, v_single}, 32'd0);
            check("rd_allowed", {31'b0, v_allow}, 32'd0);
            if (busy_en) begin
                v_exp_busy = ~cs_hist[SYNC_STAGES-2];
                v_busy     = busy;
                check("busy", {31'b0, v_busy}, {31'b0, v_exp_busy});
            end
            if (mem_if.o_MEM_RD) rd_log.push_back(mem_if.o_MEM_ADDR);
        end
        prev_rd = mem_if.o_MEM_RD;
        cs_hist = {cs_hist[6:0], spi_cs};
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic spi_bits(input logic [7:0] b, input int nb,
                            output logic [7:0] r, output logic [7:0] oe);
        r  = 8'h00;
        oe = 8'h00;
        for (int i = 7; i >= 8 - nb; i--) begin
            spi_mosi = b[i];
            repeat (HALF) @(negedge clk);
            r[i]    = miso;
            oe[i]   = miso_oe;
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clk);
            spi_sck = 1'b0;
        end
    endtask

    task automatic xbyte(input string nm, input logic [7:0] b,
                         input logic [7:0] exp_rx, input logic [7:0] exp_oe);
        logic [7:0] r, oe;
        spi_bits(b, 8, r, oe);
        rx_seen.push_back(r);
        check({nm, "_miso"}, {24'b0, r}, {24'b0, exp_rx});
        check({nm, "_oe"}, {24'b0, oe}, {24'b0, exp_oe});
    endtask

    task automatic cs_low();
        rx_seen.delete();
        rd_log.delete();
        spi_cs = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        spi_cs = 1'b1;
        repeat (3 * HALF) @(negedge clk);
    endtask

    // READ / FAST_READ of n bytes at a. Every byte, including the last,
    // triggers a prefetch, so n+1 sequential reads are expected.
    task automatic read_txn(input string nm, input logic [7:0] op,
                            input logic [ADDR_W-1:0] a, input int n, input bit dummy);
        logic [23:0] a24;
        a24   = 24'(a);
        rd_ok = 1'b1;
        cs_low();
        xbyte({nm, "_cmd"}, op, 8'h00, 8'h00);
        xbyte({nm, "_a2"}, a24[23:16], 8'h00, 8'h00);
        xbyte({nm, "_a1"}, a24[15:8], 8'h00, 8'h00);
        xbyte({nm, "_a0"}, a24[7:0], 8'h00, 8'h00);
        if (dummy) xbyte({nm, "_dummy"}, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < n; i++)
            xbyte({nm, "_data"}, 8'h00, mem[ADDR_W'(32'(a) + i)], 8'hFF);
        cs_high();
        check({nm, "_rd_count"}, 32'(rd_log.size()), 32'(n + 1));
        for (int i = 0; i <= n && i < rd_log.size(); i++)
            check({nm, "_rd_addr"}, 32'(rd_log[i]), 32'(ADDR_W'(32'(a) + i)));
        rd_ok = 1'b0;
    endtask

    initial begin
        logic [7:0] r, oe;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i) ^ 8'h5A;
        mem[12'h123] = 8'hA5;
        mem[12'hFFE] = 8'h11;
        mem[12'hFFF] = 8'h22;
        mem[12'h000] = 8'h33;
        mem[12'h010] = 8'h7E;

        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_oe", {31'b0, miso_oe}, 32'd0);
        check("rst_miso", {31'b0, miso}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_rd", {31'b0, mem_if.o_MEM_RD}, 32'd0);
        check("rst_addr", 32'(mem_if.o_MEM_ADDR), 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        mon_en  = 1'b1;
        busy_en = 1'b1;

        // READ at 0x123, one byte
        read_txn("rd123", 8'h03, 12'h123, 1, 1'b0);
        check("pin_a5", {24'b0, rx_seen[4]}, 32'h0000_00A5);

        // READ across the top of memory
        read_txn("wrap", 8'h03, 12'hFFE, 3, 1'b0);
        check("pin_wrap0", {24'b0, rx_seen[4]}, 32'h11);
        check("pin_wrap1", {24'b0, rx_seen[5]}, 32'h22);
        check("pin_wrap2", {24'b0, rx_seen[6]}, 32'h33);
        check("pin_wrap_addr", (rd_log.size() > 2) ? 32'(rd_log[2]) : 32'hDEAD, 32'h000);

        // RDID
        cs_low();
        xbyte("rdid_cmd", 8'h9F, 8'h00, 8'h00);
        xbyte("rdid_b0", 8'h00, 8'hEF, 8'hFF);
        xbyte("rdid_b1", 8'h00, 8'h40, 8'hFF);
        xbyte("rdid_b2", 8'h00, 8'h16, 8'hFF);
        xbyte("rdid_b3", 8'h00, 8'h00, 8'hFF);
        cs_high();

        // Unknown opcode, then RDSR
        cs_low();
        xbyte("ign_cmd", 8'hAB, 8'h00, 8'h00);
        xbyte("ign_b0", 8'hFF, 8'h00, 8'h00);
        xbyte("ign_b1", 8'h55, 8'h00, 8'h00);
        cs_high();
        cs_low();
        xbyte("rdsr_cmd", 8'h05, 8'h00, 8'h00);
        xbyte("rdsr_b0", 8'h00, 8'h00, 8'hFF);
        cs_high();

        // READ aborted after 12 address bits
        rd_ok = 1'b0;
        cs_low();
        xbyte("abort_cmd", 8'h03, 8'h00, 8'h00);
        xbyte("abort_a2", 8'h00, 8'h00, 8'h00);
        spi_bits(8'h01, 4, r, oe);
        spi_cs = 1'b1;
        repeat (SYNC_STAGES + 1) @(posedge clk);
        #1;
        check("abort_oe", {31'b0, miso_oe}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        repeat (3 * HALF) @(negedge clk);
        check("abort_no_rd", 32'(rd_log.size()), 32'd0);
        read_txn("rd010", 8'h03, 12'h010, 1, 1'b0);
        check("pin_7e", {24'b0, rx_seen[4]}, 32'h7E);

`ifdef SPI_FAST_READ_EN
        read_txn("fast", 8'h0B, 12'h010, 1, 1'b1);
        check("pin_fast", {24'b0, rx_seen[5]}, 32'h7E);
`else
        cs_low();
        xbyte("fast_ign_cmd", 8'h0B, 8'h00, 8'h00);
        xbyte("fast_ign_b0", 8'h00, 8'h00, 8'h00);
        xbyte("fast_ign_b1", 8'h00, 8'h00, 8'h00);
        cs_high();
`endif

        // Reset in the middle of a DATA byte
        rd_ok = 1'b1;
        cs_low();
        xbyte("mid_cmd", 8'h03, 8'h00, 8'h00);
        xbyte("mid_a2", 8'h00, 8'h00, 8'h00);
        xbyte("mid_a1", 8'h00, 8'h00, 8'h00);
        xbyte("mid_a0", 8'h55, 8'h00, 8'h00);
        xbyte("mid_data", 8'h00, mem[12'h055], 8'hFF);
        spi_bits(8'h00, 3, r, oe);
        busy_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_oe", {31'b0, miso_oe}, 32'd0);
        check("mid_rst_miso", {31'b0, miso}, 32'd0);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_rd", {31'b0, mem_if.o_MEM_RD}, 32'd0);
        check("mid_rst_addr", 32'(mem_if.o_MEM_ADDR), 32'd0);
        spi_cs = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        rd_ok = 1'b0;
        repeat (8) @(negedge clk);
        busy_en = 1'b1;

        // Recovery after reset
        cs_low();
        xbyte("post_rdsr_cmd", 8'h05, 8'h00, 8'h00);
        xbyte("post_rdsr_b0", 8'h00, 8'h00, 8'hFF);
        cs_high();

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
